// File: rtl/led_pattern_engine.sv
// led_pattern_engine: LED animator with a built-in tick prescaler, a speed
// counter, four animation modes (bounce, rotate-left, rotate-right, bar),
// pause, and a one-cycle step strobe for every new LED pattern.
module led_pattern_engine #(
    parameter int N_LED    = 8,
    parameter int N_SPEED  = 8,
    parameter int TICK_DIV = 400000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic [N_SPEED-1:0] speed,
    input  logic               pause,
    output logic [N_LED-1:0]   leds,
    output logic               step,
    output logic               dir
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_ROL    = 2'd1,
        MODE_ROR    = 2'd2,
        MODE_BAR    = 2'd3
    } mode_t;

    logic [PW-1:0]      presc_reg;
    logic               tick;
    logic [N_SPEED-1:0] cnt_reg;
    logic [N_SPEED-1:0] limit;
    mode_t              mode_reg;
    mode_t              mode_in;
    logic [N_LED-1:0]   leds_reg;
    logic [N_LED-1:0]   leds_next;
    logic               dir_reg;
    logic               dir_next;
    logic               step_reg;
    logic [N_LED-1:0]   rol;
    logic [N_LED-1:0]   ror;
    logic [N_LED-1:0]   fill;
    logic [N_LED-1:0]   drain;

    assign mode_in = mode_t'(mode);
    assign tick    = (presc_reg == PW'(TICK_DIV - 1));
    // (2^N_SPEED-1) - speed is simply the bitwise complement at this width.
    assign limit   = ~speed;

    assign rol   = {leds_reg[N_LED-2:0], leds_reg[N_LED-1]};
    assign ror   = {leds_reg[0], leds_reg[N_LED-1:1]};
    assign fill  = {leds_reg[N_LED-2:0], 1'b1};
    assign drain = leds_reg >> 1;

    assign leds = leds_reg;
    assign dir  = dir_reg;
    assign step = step_reg;

    // Free-running prescaler; ignores pause and mode changes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // Next pattern and direction for one advance in the current mode.
    always_comb begin
        leds_next = leds_reg;
        dir_next  = dir_reg;
        case (mode_reg)
            MODE_BOUNCE: begin
                // Direction flips as soon as an end LED is reached, so the
                // end LED is shown for exactly one step.
                if (dir_reg) begin
                    if (leds_reg[N_LED-1]) begin
                        leds_next = ror;
                        dir_next  = 1'b0;
                    end else begin
                        leds_next = rol;
                        dir_next  = ~rol[N_LED-1];
                    end
                end else begin
                    if (leds_reg[0]) begin
                        leds_next = rol;
                        dir_next  = 1'b1;
                    end else begin
                        leds_next = ror;
                        dir_next  = ror[0];
                    end
                end
            end
            MODE_ROL: begin
                leds_next = rol;
                dir_next  = 1'b1;
            end
            MODE_ROR: begin
                leds_next = ror;
                dir_next  = 1'b0;
            end
            MODE_BAR: begin
                if (dir_reg) begin
                    leds_next = fill;
                    dir_next  = ~(&fill);
                end else begin
                    leds_next = drain;
                    dir_next  = ~(|drain);
                end
            end
            default: begin
                leds_next = leds_reg;
                dir_next  = dir_reg;
            end
        endcase
    end

    // Animation state: reset > mode change > pause > advance on tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            leds_reg <= N_LED'(1);
            dir_reg  <= 1'b1;
            step_reg <= 1'b0;
            cnt_reg  <= '0;
            mode_reg <= mode_in;
        end else if (mode_in != mode_reg) begin
            mode_reg <= mode_in;
            leds_reg <= N_LED'(1);
            dir_reg  <= 1'b1;
            step_reg <= 1'b0;
            cnt_reg  <= '0;
        end else if (pause) begin
            step_reg <= 1'b0;
        end else if (tick) begin
            if (cnt_reg >= limit) begin
                cnt_reg  <= '0;
                leds_reg <= leds_next;
                dir_reg  <= dir_next;
                step_reg <= 1'b1;
            end else begin
                cnt_reg  <= cnt_reg + 1'b1;
                step_reg <= 1'b0;
            end
        end else begin
            step_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine (N_LED=4, N_SPEED=2, TICK_DIV=2).
// Stimulus pushes the expected pattern, direction and cycle gap of every
// step; the monitor pops and compares on each step pulse.
module tb_led_pattern_engine;

    logic       clk;
    logic       reset;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       pause;
    logic [3:0] leds;
    logic       step;
    logic       dir;

    typedef struct {
        logic [3:0] leds;
        logic       dir;
        int         gap;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rst_cyc = 0;
    int   last_step = 0;

    led_pattern_engine #(
        .N_LED    (4),
        .N_SPEED  (2),
        .TICK_DIV (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .speed (speed),
        .pause (pause),
        .leds  (leds),
        .step  (step),
        .dir   (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] l, input logic d, input int g);
        exp_t e;
        e.leds = l;
        e.dir  = d;
        e.gap  = g;
        q.push_back(e);
    endtask

    // Cycle counter; remembers the last cycle the DUT was held in reset.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) rst_cyc = cyc;
    end

    // Monitor: every step pulse pops one expected entry and compares it.
    always @(negedge clk) begin
        exp_t e;
        int   ref_cyc;
        if (step) begin
            ref_cyc = (last_step > rst_cyc) ? last_step : rst_cyc;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_step actual leds=%b dir=%b required no step", leds, dir);
            end else begin
                e = q.pop_front();
                $display("step leds=%b dir=%b gap=%0d (req %b %b %0d)",
                         leds, dir, cyc - ref_cyc, e.leds, e.dir, e.gap);
                chk("step_leds", 32'(leds), 32'(e.leds));
                chk("step_dir",  32'(dir),  32'(e.dir));
                chk("step_gap",  32'(cyc - ref_cyc), 32'(e.gap));
            end
            last_step = cyc;
        end
    end

    task automatic do_reset(input logic [1:0] m, input logic [1:0] s);
        reset = 1'b0;
        mode  = m;
        speed = s;
        pause = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("reset_state", 32'({leds, dir, step}), 32'({4'b0001, 1'b1, 1'b0}));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout actual pending=%0d required 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        reset = 1'b0;
        mode  = 2'd0;
        speed = 2'd3;
        pause = 1'b0;

        // Bounce at full speed
        do_reset(2'd0, 2'd3);
        push(4'b0010, 1'b1, 2);
        push(4'b0100, 1'b1, 2);
        push(4'b1000, 1'b0, 2);
        push(4'b0100, 1'b0, 2);
        push(4'b0010, 1'b0, 2);
        push(4'b0001, 1'b1, 2);
        push(4'b0010, 1'b1, 2);
        drain("bounce");

        // Slowest speed, then speed=2 mid-run
        do_reset(2'd0, 2'd0);
        push(4'b0010, 1'b1, 8);
        repeat (8) @(negedge clk);
        speed = 2'd2;
        push(4'b0100, 1'b1, 4);
        push(4'b1000, 1'b0, 4);
        drain("speed");

        // Rotate-right
        do_reset(2'd2, 2'd3);
        push(4'b1000, 1'b0, 2);
        push(4'b0100, 1'b0, 2);
        push(4'b0010, 1'b0, 2);
        push(4'b0001, 1'b0, 2);
        drain("rotate_right");

        // Rotate-left
        do_reset(2'd1, 2'd3);
        push(4'b0010, 1'b1, 2);
        push(4'b0100, 1'b1, 2);
        push(4'b1000, 1'b1, 2);
        push(4'b0001, 1'b1, 2);
        drain("rotate_left");

        // Bar fill/drain
        do_reset(2'd3, 2'd3);
        push(4'b0011, 1'b1, 2);
        push(4'b0111, 1'b1, 2);
        push(4'b1111, 1'b0, 2);
        push(4'b0111, 1'b0, 2);
        push(4'b0011, 1'b0, 2);
        push(4'b0001, 1'b0, 2);
        push(4'b0000, 1'b1, 2);
        push(4'b0001, 1'b1, 2);
        drain("bar");

        // Pause at 0100 for 10 cycles; ticks during pause are lost
        do_reset(2'd0, 2'd3);
        push(4'b0010, 1'b1, 2);
        push(4'b0100, 1'b1, 2);
        repeat (4) @(negedge clk);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("pause_hold", 32'({leds, dir, step}), 32'({4'b0100, 1'b1, 1'b0}));
        end
        pause = 1'b0;
        push(4'b1000, 1'b0, 12);
        drain("pause");

        // Mode change 0->3 at 1000, coincident with a tick
        do_reset(2'd0, 2'd3);
        push(4'b0010, 1'b1, 2);
        push(4'b0100, 1'b1, 2);
        push(4'b1000, 1'b0, 2);
        repeat (7) @(negedge clk);
        chk("pre_mode_change", 32'(leds), 32'(4'b1000));
        mode = 2'd3;
        @(negedge clk);
        chk("mode_change", 32'({leds, dir, step}), 32'({4'b0001, 1'b1, 1'b0}));
        push(4'b0011, 1'b1, 4);
        drain("mode_change");

        // Reset mid-bar at 0111
        do_reset(2'd3, 2'd3);
        push(4'b0011, 1'b1, 2);
        push(4'b0111, 1'b1, 2);
        repeat (4) @(negedge clk);
        chk("pre_reset", 32'(leds), 32'(4'b0111));
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset", 32'({leds, dir, step}), 32'({4'b0001, 1'b1, 1'b0}));
        reset = 1'b1;
        push(4'b0011, 1'b1, 2);
        drain("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Second-generation LED animator with programmable speed.
- Built-in tick prescaler, so no external divider instance is needed.
- Selectable animation modes: bounce, rotate-left wrap, rotate-right wrap, and fill/drain bar.
- Adds pause and a step strobe. Sits between board-level control registers/switches and the LED pins.

Parameters:
- N_LED, 8, number of LEDs; must be >= 2
- N_SPEED, 8, width of speed input
- TICK_DIV, 400000, clk cycles per prescaler tick (100 MHz / 250 Hz); must be >= 2

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- mode  input  2  animation select: 0 bounce, 1 rotate-left, 2 rotate-right, 3 bar
- speed  input  N_SPEED  higher value = faster stepping
- pause  input  1  freeze animation while high
- leds  output  N_LED  LED drive, bit0 = rightmost
- step  output  1  one-cycle pulse in the cycle a new leds value first appears
- dir  output  1  current direction: 1 = left/fill, 0 = right/drain

Behaviour:
- Reset (reset==0 at a rising edge) has priority over everything. Reset values:
  - leds=1, dir=1, step=0
  - prescaler=0, speed counter=0
  - mode_reg=mode
- Reset mid-animation discards all progress.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - Internal tick is high for one cycle when count==TICK_DIV-1.
  - First tick occurs TICK_DIV cycles after reset deasserts.
  - Runs regardless of pause and mode changes.
- Speed counter (N_SPEED bits):
  - limit = (2^N_SPEED-1) - speed, computed unsigned at N_SPEED width.
  - On tick with counter >= limit: counter <= 0 and an advance occurs.
  - On tick otherwise: counter <= counter+1.
  - speed = max gives an advance every tick; speed = 0 gives an advance every 2^N_SPEED ticks.
  - speed changes take effect at the next tick compare.
- Priority per cycle: reset > mode change > pause > advance.
- Mode change (mode != mode_reg), effective the cycle after detection:
  - mode_reg <= mode, leds <= 1, dir <= 1, counter <= 0, step = 0.
  - The prescaler is untouched.
  - A mode change in the same cycle as an advancing tick suppresses that advance.
- Pause:
  - While pause==1, counter, leds and dir hold and step=0.
  - Ticks are lost, not queued.
  - On release, counting resumes at the next tick from the held counter value.
- Advance, registered; leds updates on the edge after the advancing tick, and step is high in that same cycle.
  - Bounce:
    - dir=1: if leds[N_LED-1] then dir <= 0 and rotate right, else rotate left.
    - dir=0: if leds[0] then dir <= 1 and rotate left, else rotate right.
    - End LEDs are lit for exactly one step.
  - Rotate-left: leds <= {leds[N_LED-2:0], leds[N_LED-1]}; dir fixed at 1.
  - Rotate-right: leds <= {leds[0], leds[N_LED-1:1]}; dir forced to 0 on the first advance.
  - Bar:
    - dir=1 (fill): leds <= {leds[N_LED-2:0],1'b1}; when the result is all ones, dir <= 0.
    - dir=0 (drain): leds <= leds>>1; when the result is 0, dir <= 1.
    - Period is 2*N_LED steps; the all-zero pattern is shown for one step.
- Exactly one bit of leds is set in modes 0–2 at all times.
- step is never high in two consecutive cycles, because TICK_DIV >= 2.

Test Plan:
- All cases use N_LED=4, N_SPEED=2, TICK_DIV=2.
- Bounce, speed=3, from reset: leds steps every 2 cycles through 0001,0010,0100,1000,0100,0010,0001,0010. step pulses coincide with each change. dir goes 0 when 1000 appears and 1 when 0001 appears.
- Speed, mode 0, speed=0: advances every 8 cycles. Switch speed to 2 mid-run: advances every 4 cycles from the next compare.
- Rotate-right, speed=3: 0001,1000,0100,0010,0001, dir=0. Rotate-left: 0001,0010,0100,1000,0001.
- Bar, speed=3: 0001,0011,0111,1111,0111,0011,0001,0000,0001. dir is 0 from 1111 through 0001, and 1 at 0000.
- Pause:
  - Assert pause for 10 cycles at leds=0100 in bounce: leds, dir and counter hold, and step stays 0.
  - Release: the next advance yields 1000 on the first qualifying tick.
- Mode change and reset:
  - Change mode 0→3 at leds=1000 coincident with a tick: next cycle leds=0001, dir=1, no step.
  - Assert reset low mid-bar at 0111: leds=0001, dir=1, step=0 after the edge. The first advance comes 2 cycles after release.
